// File: rtl/entropy_seed_src.sv
// entropy_seed_src
//   Producer side of the Zkr seed CSR. Raw ring-oscillator samples are
//   health-tested online (repetition-count test, plus an optional
//   adaptive-proportion test), packed LSB-first into 16-bit words and
//   buffered in a small FIFO. The CSR read logic sees OPST plus the FIFO head.
//
// Ports
//   clk          clock
//   reset        synchronous, active-low reset
//   RawBit       raw noise sample
//   RawValid     RawBit valid this cycle
//   SourceEnable enables the noise source (low when FIFO full or DEAD)
//   SeedReadM    seed CSR accessed with write; pops one word in ES16
//   SeedValM     seed CSR read value {.., OPST[31:30], 0, entropy[15:0]}
//   HealthFail   one-cycle pulse on any health-test failure
//
// Optional feature
//   ENTROPY_APT_EN  when defined, adds an adaptive-proportion test over
//                   non-overlapping 256-sample windows (ones <80 or >176 fail).
module entropy_seed_src #(
    parameter int XLEN         = 64,
    parameter int FIFO_DEPTH   = 4,
    parameter int WARMUP_WORDS = 2,
    parameter int RCT_CUTOFF   = 32,
    parameter int MAX_FAILS    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RawBit,
    input  logic            RawValid,
    output logic            SourceEnable,
    input  logic            SeedReadM,
    output logic [XLEN-1:0] SeedValM,
    output logic            HealthFail
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int WW = $clog2(WARMUP_WORDS + 1);

    typedef enum logic [1:0] {
        ST_BIST = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_t;

    state_t          state, state_next;

    logic [15:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [14:0]     shreg;
    logic [3:0]      bit_cnt;
    logic [RW-1:0]   rct_cnt;
    logic [FW-1:0]   fail_cnt;
    logic [WW-1:0]   warm_cnt;
    logic            health_fail;

    logic            empty, full, es16, pop, accept, word_done, push;
    logic            rct_fail, apt_fail, fail_now;
    logic [RW-1:0]   rct_next;
    logic [15:0]     word;
    logic [1:0]      opst;

    always_comb begin
        empty     = (count == '0);
        full      = (count == CW'(FIFO_DEPTH));
        es16      = (state == ST_RUN) && !empty;
        pop       = SeedReadM && es16;
        // A full FIFO stalls the sampler unless a pop frees a slot this cycle.
        accept    = RawValid && (state != ST_DEAD) && (!full || pop);
        word_done = accept && (bit_cnt == 4'd15);
        word      = {RawBit, shreg};
        // shreg[14] is the most recently accepted sample; rct_cnt==0 marks
        // "no previous sample" after reset or a flush.
        rct_next  = ((rct_cnt != '0) && (RawBit == shreg[14])) ? rct_cnt + 1'b1 : RW'(1);
        rct_fail  = accept && (rct_next == RW'(RCT_CUTOFF));
        fail_now  = rct_fail || apt_fail;
        push      = word_done && (state == ST_RUN) && !fail_now;
    end

`ifdef ENTROPY_APT_EN
    logic [7:0] apt_n;
    logic [8:0] apt_ones;
    logic [8:0] apt_total;

    always_comb begin
        apt_total = apt_ones + {8'd0, RawBit};
        apt_fail  = accept && (apt_n == 8'hFF) &&
                    ((apt_total < 9'd80) || (apt_total > 9'd176));
    end

    // Any failure either returns to BIST or parks in DEAD, so clearing the
    // window on fail_now restarts it on every return to BIST.
    always_ff @(posedge clk) begin
        if (!reset || fail_now) begin
            apt_n    <= '0;
            apt_ones <= '0;
        end else if (accept) begin
            apt_n    <= apt_n + 8'd1;
            apt_ones <= (apt_n == 8'hFF) ? 9'd0 : apt_total;
        end
    end
`else
    always_comb apt_fail = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_BIST: begin
                if (fail_now)
                    state_next = ST_DEAD;
                else if (word_done && (warm_cnt == WW'(WARMUP_WORDS - 1)))
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (fail_now)
                    state_next = (fail_cnt == FW'(MAX_FAILS - 1)) ? ST_DEAD : ST_BIST;
            end
            ST_DEAD: state_next = ST_DEAD;
            default: state_next = ST_DEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_BIST;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            bit_cnt     <= '0;
            rct_cnt     <= '0;
            fail_cnt    <= '0;
            warm_cnt    <= '0;
            health_fail <= 1'b0;
        end else begin
            state       <= state_next;
            health_fail <= fail_now;
            if (fail_now) begin
                // Failure beats a same-cycle pop or push: everything is flushed.
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                bit_cnt  <= '0;
                rct_cnt  <= '0;
                warm_cnt <= '0;
                if (state == ST_RUN)
                    fail_cnt <= fail_cnt + 1'b1;
            end else begin
                if (accept) begin
                    bit_cnt <= bit_cnt + 4'd1;
                    rct_cnt <= rct_next;
                end
                if (word_done && (state == ST_BIST))
                    warm_cnt <= warm_cnt + 1'b1;
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Datapath storage carries no reset; bit_cnt/count qualify its contents.
    always_ff @(posedge clk) begin
        if (accept)
            shreg <= word[15:1];
        if (push)
            fifo_mem[wr_ptr] <= word;
    end

    always_comb begin
        case (state)
            ST_BIST: opst = 2'b00;
            ST_RUN:  opst = empty ? 2'b01 : 2'b10;
            default: opst = 2'b11;
        endcase
        SeedValM        = '0;
        SeedValM[31:30] = opst;
        if (es16)
            SeedValM[15:0] = fifo_mem[rd_ptr];
        SourceEnable = !full && (state != ST_DEAD);
        HealthFail   = health_fail;
    end

endmodule

// File: tb/tb_entropy_seed_src.sv
module tb_entropy_seed_src;

    localparam int DEPTH = 4;
    localparam int WARM  = 2;
    localparam int CUT   = 32;
    localparam int MAXF  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        RawBit;
    logic        RawValid;
    logic        SeedReadM;
    logic        SourceEnable;
    logic        HealthFail;
    logic [63:0] SeedValM;

    int checks   = 0;
    int failures = 0;
    int hf_seen  = 0;

    always #5 clk = ~clk;

    entropy_seed_src #(
        .XLEN(64), .FIFO_DEPTH(DEPTH), .WARMUP_WORDS(WARM),
        .RCT_CUTOFF(CUT), .MAX_FAILS(MAXF)
    ) dut (
        .clk(clk), .reset(reset), .RawBit(RawBit), .RawValid(RawValid),
        .SourceEnable(SourceEnable), .SeedReadM(SeedReadM),
        .SeedValM(SeedValM), .HealthFail(HealthFail)
    );

    // Reference model: 0=BIST 1=RUN 2=DEAD, FIFO as a queue.
    int          m_state;
    logic [15:0] m_q[$];
    logic [15:0] m_word;
    int          m_nbits, m_run, m_fails, m_warm, m_win_n, m_win_ones;
    logic        m_last;
    logic        m_hf;

    function automatic logic [63:0] m_seed();
        if (m_state == 0) return 64'h0;
        if (m_state == 2) return 64'hC000_0000;
        if (m_q.size() == 0) return 64'h4000_0000;
        return {48'h0000_0000_8000, m_q[0]};
    endfunction

    function automatic logic m_se();
        return (m_state != 2) && (m_q.size() < DEPTH);
    endfunction

    task automatic model_reset();
        m_state = 0; m_q.delete(); m_word = '0; m_nbits = 0; m_run = 0;
        m_fails = 0; m_warm = 0; m_win_n = 0; m_win_ones = 0; m_last = 0; m_hf = 0;
    endtask

    task automatic model_edge(input logic rv, input logic rb, input logic rd);
        bit popping, take, fail, done;
        logic [15:0] w;
        popping = rd && (m_state == 1) && (m_q.size() > 0);
        take    = rv && (m_state != 2) && ((m_q.size() < DEPTH) || popping);
        fail = 0; done = 0; w = '0;
        m_hf = 0;
        if (!take) begin
            if (popping) void'(m_q.pop_front());
            return;
        end
        if (m_run > 0 && rb == m_last) m_run++; else m_run = 1;
        m_last = rb;
        if (m_run >= CUT) fail = 1;
`ifdef ENTROPY_APT_EN
        m_win_n++;
        m_win_ones += int'(rb);
        if (m_win_n == 256) begin
            if (m_win_ones < 80 || m_win_ones > 176) fail = 1;
            m_win_n = 0; m_win_ones = 0;
        end
`endif
        m_word[m_nbits] = rb;
        m_nbits++;
        if (m_nbits == 16) begin done = 1; w = m_word; m_nbits = 0; end
        if (fail) begin
            m_hf = 1; m_q.delete(); m_nbits = 0; m_run = 0;
            m_win_n = 0; m_win_ones = 0; m_warm = 0;
            if (m_state == 0) m_state = 2;
            else begin
                m_fails++;
                m_state = (m_fails >= MAXF) ? 2 : 0;
            end
            return;
        end
        if (popping) void'(m_q.pop_front());
        if (done) begin
            if (m_state == 0) begin
                m_warm++;
                if (m_warm == WARM) m_state = 1;
            end else m_q.push_back(w);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("seed_vs_model", SeedValM, m_seed());
        chk("srcen_vs_model", {63'd0, SourceEnable}, {63'd0, m_se()});
        chk("hfail_vs_model", {63'd0, HealthFail}, {63'd0, m_hf});
    endtask

    task automatic step(input logic rv, input logic rb, input logic rd);
        chk_all();
        RawValid = rv; RawBit = rb; SeedReadM = rd;
        @(posedge clk);
        model_edge(rv, rb, rd);
        #1;
        if (HealthFail === 1'b1) hf_seen++;
    endtask

    task automatic do_reset();
        reset = 1'b0; RawValid = 1'b0; RawBit = 1'b0; SeedReadM = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b1;
        chk_all();
    endtask

    // Alternating warm-up: starts with 1, ends with 0.
    task automatic warmup();
        for (int i = 0; i < 32; i++) step(1'b1, (i % 2) == 0, 1'b0);
    endtask

    task automatic feed_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) step(1'b1, w[i], 1'b0);
    endtask

    initial begin
        logic [15:0] wv;
        logic rb;
        int hf_before;

        // Reset state, warm-up and first word
        do_reset();
        chk("rst_seed", SeedValM, 64'h0);
        chk("rst_srcen", {63'd0, SourceEnable}, 64'd1);
        chk("rst_hfail", {63'd0, HealthFail}, 64'd0);
        for (int i = 0; i < 31; i++) step(1'b1, (i % 2) == 0, 1'b0);
        chk("warm_opst", {62'd0, SeedValM[31:30]}, 64'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("wait_after_warm", SeedValM, 64'h4000_0000);
        wv = 16'h1234;
        for (int i = 0; i < 15; i++) step(1'b1, wv[i], 1'b0);
        chk("wait_before_16th", SeedValM, 64'h4000_0000);
        step(1'b1, wv[15], 1'b0);
        chk("first_word", SeedValM, 64'h8000_1234);

        // Pop to WAIT, then pop in WAIT has no effect
        step(1'b0, 1'b0, 1'b1);
        chk("pop_to_wait", SeedValM, 64'h4000_0000);
        step(1'b0, 1'b0, 1'b1);
        chk("pop_in_wait", SeedValM, 64'h4000_0000);
        chk("srcen_wait", {63'd0, SourceEnable}, 64'd1);

        // Fill the FIFO, ignored samples while full, pops
        feed_word(16'hA5A5);
        feed_word(16'h5A5A);
        feed_word(16'h0F0F);
        feed_word(16'hF0F0);
        chk("full_srcen", {63'd0, SourceEnable}, 64'd0);
        chk("full_head", SeedValM, 64'h8000_A5A5);
        for (int i = 0; i < 8; i++) step(1'b1, i[0], 1'b0);
        chk("ignored_head", SeedValM, 64'h8000_A5A5);
        step(1'b0, 1'b0, 1'b1);
        chk("pop_head", SeedValM, 64'h8000_5A5A);
        chk("pop_srcen", {63'd0, SourceEnable}, 64'd1);
        feed_word(16'h1357);
        step(1'b0, 1'b0, 1'b1);
        chk("pop_0f0f", SeedValM, 64'h8000_0F0F);
        step(1'b0, 1'b0, 1'b1);
        chk("pop_f0f0", SeedValM, 64'h8000_F0F0);
        step(1'b0, 1'b0, 1'b1);
        chk("pop_1357", SeedValM, 64'h8000_1357);
        wv = 16'h2468;
        for (int i = 0; i < 15; i++) step(1'b1, wv[i], 1'b0);
        step(1'b1, wv[15], 1'b1);
        chk("push_pop_one", SeedValM, 64'h8000_2468);

        // Reset mid-operation clears the FIFO
        do_reset();
        chk("midrst_seed", SeedValM, 64'h0);

        // RCT failure in RUN, re-warm-up, second failure -> DEAD
        warmup();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0);
        chk("rct1_pulse", {63'd0, HealthFail}, 64'd1);
        chk("rct1_seed", SeedValM, 64'h0);
        step(1'b0, 1'b0, 1'b0);
        chk("rct1_pulse_end", {63'd0, HealthFail}, 64'd0);
        warmup();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b0);
        chk("rct2_seed", SeedValM, 64'hC000_0000);
        chk("rct2_srcen", {63'd0, SourceEnable}, 64'd0);
        for (int i = 0; i < 40; i++) step(1'b1, i[1], 1'b1);
        chk("dead_sticky", SeedValM, 64'hC000_0000);

        // Failure during BIST
        do_reset();
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0);
        chk("bist_fail_dead", SeedValM, 64'hC000_0000);
        chk("bist_fail_srcen", {63'd0, SourceEnable}, 64'd0);

        // 256-sample window with 200 ones and no long run
        do_reset();
        hf_before = hf_seen;
        warmup();
        for (int i = 0; i < 224; i++) step(1'b1, (i % 28) < 23, 1'b1);
        step(1'b0, 1'b0, 1'b0);
`ifdef ENTROPY_APT_EN
        chk("apt_fail_count", 64'(hf_seen - hf_before), 64'd1);
`else
        chk("apt_fail_count", 64'(hf_seen - hf_before), 64'd0);
`endif

        // Randomized segments, alternating between fair and sticky bit streams
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            rb = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if (seg % 2 == 0) rb = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 99) < 4) rb = ~rb;
                step($urandom_range(0, 99) < 80, rb, $urandom_range(0, 99) < 20);
            end
        end
        chk_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/entropy_seed_src.md
Name: entropy_seed_src

Overview:
- Producer side of the Zkr seed CSR. Collects raw noise bits from a ring-oscillator entropy source and runs online health tests on them.
- Packs the bits into 16-bit words, buffers them in a small FIFO, and presents the seed CSR value (OPST plus entropy) to the CSR read logic.
- A CSR read-with-write of seed pops one word.
- Sits between the noise source and the privileged CSR unit.

Parameters:
- XLEN, 64, width of the seed value returned to CSR read mux (32 or 64)
- FIFO_DEPTH, 4, number of 16-bit entropy words buffered (power of 2, >=2)
- WARMUP_WORDS, 2, 16-bit words discarded in BIST before entropy is served
- RCT_CUTOFF, 32, consecutive identical raw bits that constitute a repetition-count failure
- MAX_FAILS, 2, health failures (outside BIST) tolerated before DEAD

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- RawBit  input  1  raw noise sample
- RawValid  input  1  RawBit valid this cycle
- SourceEnable  output  1  enables noise source
- SeedReadM  input  1  seed CSR accessed with write (consume pulse)
- SeedValM  output  XLEN  seed CSR read value
- HealthFail  output  1  one-cycle pulse on any health-test failure

Behaviour:
- Reset (reset==0 at a clk edge): state BIST, FIFO empty, bit counter 0, RCT counter 0, fail counter 0, HealthFail 0, SourceEnable 1.
- Main FSM states: BIST, RUN, DEAD.
- OPST encoding:
  - BIST -> 2'b00
  - RUN with FIFO empty -> 2'b01 (WAIT)
  - RUN with FIFO non-empty -> 2'b10 (ES16)
  - DEAD -> 2'b11
- SeedValM layout:
  - [31:30] = OPST
  - [29:16] = 0
  - [15:0] = FIFO head only when OPST==ES16, else 0
  - [XLEN-1:32] = 0
  - Combinational from registered state; entropy is never exposed outside ES16.
- Packing: each RawValid sample shifts into a 16-bit word, first sample at bit 0. On the 16th sample the word completes and the counter wraps to 0.
  - In BIST, completed words are counted and discarded.
  - In RUN, completed words are pushed to the FIFO; the word is visible on SeedValM the cycle after the clk edge that captured the 16th sample.
- Full FIFO:
  - RawValid is ignored (counter and RCT hold) while FIFO is full and no pop occurs that cycle.
  - SourceEnable = ~full & (state!=DEAD).
  - Push while full is accepted only with a same-cycle pop.
- Pop: SeedReadM==1 while OPST==ES16 removes the head at the next edge.
  - SeedReadM in BIST/WAIT/DEAD has no effect.
  - Simultaneous push and pop with 1 entry: count stays 1, state stays ES16.
- RCT: counts consecutive equal valid samples, including across word boundaries. Reaching RCT_CUTOFF is a failure; the counter resets to 1 on a differing bit.
- Failure handling: HealthFail pulses 1 cycle.
  - In BIST: go to DEAD.
  - In RUN: fail counter++, flush FIFO, clear bit/RCT counters, go to BIST (warm-up restarts). If fail counter reaches MAX_FAILS, go to DEAD instead.
- BIST -> RUN after WARMUP_WORDS complete words with no failure.
- DEAD is sticky until reset: SourceEnable 0, FIFO ignored, SeedValM = 32'hC000_0000 zero-extended.
- Failure and pop in the same cycle: failure wins; FIFO flushed.
- Reset mid-operation: all state cleared at the next edge regardless of FIFO contents.

Optional Feature:
- Macro: ENTROPY_APT_EN
- Defined: adds an adaptive-proportion test over non-overlapping 256-sample windows. A count of ones <80 or >176 at window end is a failure, handled identically to an RCT failure. The window counter clears on reset and on any return to BIST.
- Undefined: no APT logic; only the RCT detects failures.

Test Plan:
- Reset then 32 alternating valid bits -> OPST 00 during warm-up; next 16 bits 0x1234 LSB-first -> OPST 10, SeedValM=0x8000_1234 one cycle after the 16th bit.
- ES16 with one word, SeedReadM pulse -> next cycle OPST 01, SeedValM=0x4000_0000; SeedReadM in WAIT -> no change.
- Fill 4 words 0xA5A5, 0x5A5A, 0x0F0F, 0xF0F0 -> SourceEnable 0, extra RawValid ignored; pop -> 0x5A5A at head, SourceEnable 1.
- In RUN, feed 32 consecutive 1s -> HealthFail pulse, FIFO flushed, OPST 00; second such failure after re-warm-up -> OPST 11, SeedValM=0xC000_0000, SourceEnable 0, stays until reset.
- Failure during BIST (32 zeros right after reset) -> immediate DEAD.
- With ENTROPY_APT_EN: 256-sample window with 200 ones (no 32-run) -> HealthFail at window end; without the macro the same stimulus -> no failure.
